rod_motion_ctrl: RTL and testbench
==================================

# rod_motion_ctrl

Multi-rod successor of the single-player motion/collision block for the foosball game. It drives NUM_RODS independent player rods. Each rod has fixed-point vertical motion with optional inertia, hard clamping to the playfield, and a per-rod kick state machine (windup, strike, cooldown). The block sits between the keypad/decoder logic and the per-rod draw and collision units, and feeds each rod's topLeftY and kick status to them once per frame.

## Interface
Parameters:
- NUM_RODS, 2: number of independent rods (1..4).
- FRAC_BITS, 6: fixed-point fraction bits (1/64 pixel).
- INITIAL_Y, 200: reset top-left Y of every rod, in pixels.
- Y_MIN, 30: lowest legal topLeftY, in pixels.
- Y_MAX, 450: bottom playfield bound; the highest legal topLeftY is Y_MAX-ROD_HEIGHT = 386.
- ROD_HEIGHT, 64: rod sprite height, in pixels.
- MAX_SPEED, 230: speed magnitude limit, in fixed-point units per frame.
- ACCEL, 40: speed change per frame, in fixed-point units per frame (inertia build only).
- WINDUP_FRAMES, 2; STRIKE_FRAMES, 4; COOLDOWN_FRAMES, 8: kick phase lengths, in frames.

Ports:
- clk  in  1  system clock.
- resetN  in  1  reset, asynchronous, active-low.
- startOfFrame  in  1  one-clk pulse per frame.
- y_up  in  NUM_RODS  per-rod up request (level).
- y_down  in  NUM_RODS  per-rod down request (level).
- kick_req  in  NUM_RODS  per-rod kick request (level or pulse).
- ball_contact  in  NUM_RODS  rod front edge touching the ball this clk.
- topLeftY  out  11*NUM_RODS  signed top-left Y per rod; rod i occupies bits [11i+10:11i].
- strike_active  out  NUM_RODS  rod is in STRIKE (used for the draw pose).
- kick_hit  out  NUM_RODS  one-clk pulse when a strike connects.

## Operation
- Per-rod state: signed 32-bit pos_fp, signed 32-bit speed, kick FSM, frame counter.
- Target speed:
  - y_up only: -MAX_SPEED.
  - y_down only: +MAX_SPEED.
  - Neither or both: 0.
- Speed update happens on startOfFrame only. Speed steps toward the target by ACCEL and never overshoots it. Speed is saturated to ±MAX_SPEED.
- Position update happens on the same startOfFrame. The new speed is added to pos_fp (pos_fp += speed_next).
- Clamp: if the result is below Y_MIN<<FRAC_BITS or above (Y_MAX-ROD_HEIGHT)<<FRAC_BITS:
  - pos_fp is set to the violated bound.
  - speed is set to 0 in the same update.
- topLeftY = pos_fp >>> FRAC_BITS (arithmetic shift, floor), truncated to 11 bits.
- Kick FSM per rod: IDLE → WINDUP → STRIKE → COOLDOWN → IDLE.
  - IDLE → WINDUP: on any clk with kick_req=1. The counter loads WINDUP_FRAMES.
  - Each subsequent startOfFrame decrements the counter. When the counter reaches 0, the FSM advances and loads the next phase length.
  - kick_req is ignored in every state except IDLE.
  - In STRIKE, the first clk with ball_contact=1 raises kick_hit for exactly one clk. Further contacts in the same strike produce no pulse (a per-strike "hit done" flag is cleared on entry to STRIKE).
- Rods are fully independent. Motion continues during every kick phase.

## Timing
- Reset values: pos_fp = INITIAL_Y<<FRAC_BITS (topLeftY = 200), speed = 0, FSM = IDLE, counters = 0, strike_active = 0, kick_hit = 0.
- Reset asserted mid-motion or mid-kick returns the rod to the reset values immediately (asynchronous).
- topLeftY, speed and FSM state change on the clk edge that samples startOfFrame=1. Outputs are valid 1 clk after the pulse.
- kick_hit is registered: it is high on the clk after ball_contact is sampled in STRIKE.
- Contact sampled on the same clk as the startOfFrame that exits STRIKE still counts, because the state is still STRIKE when sampled.
- kick_req and startOfFrame in the same clk in IDLE: enter WINDUP. That startOfFrame is not counted.
- strike_active is a registered decode of state == STRIKE.

## Configuration
- ROD_MOTION_INERTIA_EN defined: acceleration behaviour as described above.
- Undefined: ACCEL is ignored and speed_next equals the target directly (0 or ±MAX_SPEED). This is legacy instant-response motion. Clamping and the kick FSM are unchanged.

## Test plan
- Inertia build, rod0 y_down held from reset for 7 frames: speeds 40,80,120,160,200,230,230; pos_fp 13860; topLeftY[0] = 216; rod1 stays at 200.
- y_down held 200 frames: topLeftY = 386 and never 387; speed reads 0 on the clamp frame. Then y_up held → topLeftY decreases down to 30 and stops there.
- Non-inertia build, y_up for 1 frame: topLeftY = (12800-230)>>6 = 196. Release → speed 0 on the next frame with no drift.
- kick_req pulse on rod1: WINDUP for 2 frames, then strike_active high for exactly 4 frames. ball_contact held the whole strike → exactly one kick_hit pulse. kick_req during COOLDOWN is ignored; a new kick is accepted after 8 frames.
- y_up and y_down both held while moving at +230 → speed decays 190,150,…,30,0 (inertia build).
- resetN pulsed mid-STRIKE while moving → all outputs return to their reset values immediately. After release, the first frame behaves as from cold reset.

Source files
------------

// File: rtl/rod_motion_ctrl.sv
// rod_motion_ctrl: per-rod fixed-point vertical motion, playfield clamping and
// a kick sequencer (IDLE -> WINDUP -> STRIKE -> COOLDOWN) for NUM_RODS rods.
// Build option: define ROD_MOTION_INERTIA_EN for accelerating motion; without
// it the speed jumps straight to the requested target (legacy response).
// Handshake note: there is no valid/ready flow here; startOfFrame is a one-clk
// strobe that qualifies every motion and phase-counter update, and kick_hit is
// a one-clk registered pulse that downstream logic consumes unconditionally.
module rod_motion_ctrl #(
   parameter int NUM_RODS        = 2,
   parameter int FRAC_BITS       = 6,
   parameter int INITIAL_Y       = 200,
   parameter int Y_MIN           = 30,
   parameter int Y_MAX           = 450,
   parameter int ROD_HEIGHT      = 64,
   parameter int MAX_SPEED       = 230,
   parameter int ACCEL           = 40,
   parameter int WINDUP_FRAMES   = 2,
   parameter int STRIKE_FRAMES   = 4,
   parameter int COOLDOWN_FRAMES = 8
) (
   input  logic                     clk,
   input  logic                     resetN,
   input  logic                     startOfFrame,
   input  logic [NUM_RODS-1:0]      y_up,
   input  logic [NUM_RODS-1:0]      y_down,
   input  logic [NUM_RODS-1:0]      kick_req,
   input  logic [NUM_RODS-1:0]      ball_contact,
   output logic [11*NUM_RODS-1:0]   topLeftY,
   output logic [NUM_RODS-1:0]      strike_active,
   output logic [NUM_RODS-1:0]      kick_hit,
   output logic [2*NUM_RODS-1:0]    kick_state_dbg
);

   typedef enum logic [1:0] {
      K_IDLE     = 2'd0,
      K_WINDUP   = 2'd1,
      K_STRIKE   = 2'd2,
      K_COOLDOWN = 2'd3
   } kick_state_e;

   // Per-frame speed step. Without inertia any step at least as large as the
   // full speed span lands on the target in one frame.
`ifdef ROD_MOTION_INERTIA_EN
   localparam int STEP = ACCEL;
`else
   localparam int STEP = (ACCEL > 2 * MAX_SPEED) ? ACCEL : 2 * MAX_SPEED;
`endif

   localparam logic signed [31:0] POS_LO   = 32'(Y_MIN << FRAC_BITS);
   localparam logic signed [31:0] POS_HI   = 32'((Y_MAX - ROD_HEIGHT) << FRAC_BITS);
   localparam logic signed [31:0] POS_INIT = 32'(INITIAL_Y << FRAC_BITS);
   localparam logic signed [31:0] SPD_MAX  = 32'(MAX_SPEED);
   localparam logic signed [31:0] STEP_S   = 32'(STEP);
   localparam logic [7:0] WINDUP_LEN   = 8'(WINDUP_FRAMES);
   localparam logic [7:0] STRIKE_LEN   = 8'(STRIKE_FRAMES);
   localparam logic [7:0] COOLDOWN_LEN = 8'(COOLDOWN_FRAMES);

   for (genvar g = 0; g < NUM_RODS; g++) begin : g_rod
      logic signed [31:0] pos_q, pos_d;
      logic signed [31:0] speed_q, speed_d;
      logic signed [31:0] target, stepped, sum;
      kick_state_e        state_q, state_d;
      logic [7:0]         cnt_q, cnt_d;
      logic               hit_done_q, hit_done_d;
      logic               hit_q, hit_d;
      logic               strike_q;

      // Motion: step speed toward the target, integrate, clamp to the playfield.
      always_comb begin
         pos_d   = pos_q;
         speed_d = speed_q;
         target  = '0;
         if (y_up[g] && !y_down[g]) begin
            target = -SPD_MAX;
         end else if (y_down[g] && !y_up[g]) begin
            target = SPD_MAX;
         end
         if (speed_q < target) begin
            stepped = (target - speed_q > STEP_S) ? speed_q + STEP_S : target;
         end else begin
            stepped = (speed_q - target > STEP_S) ? speed_q - STEP_S : target;
         end
         if (stepped > SPD_MAX) begin
            stepped = SPD_MAX;
         end else if (stepped < -SPD_MAX) begin
            stepped = -SPD_MAX;
         end
         sum = pos_q + stepped;
         if (startOfFrame) begin
            if (sum < POS_LO) begin
               pos_d   = POS_LO;
               speed_d = '0;
            end else if (sum > POS_HI) begin
               pos_d   = POS_HI;
               speed_d = '0;
            end else begin
               pos_d   = sum;
               speed_d = stepped;
            end
         end
      end

      // Kick sequencer: next state, phase counter and single-shot hit detection.
      always_comb begin
         state_d    = state_q;
         cnt_d      = cnt_q;
         hit_done_d = hit_done_q;
         hit_d      = 1'b0;
         if (state_q == K_STRIKE && ball_contact[g] && !hit_done_q) begin
            hit_d      = 1'b1;
            hit_done_d = 1'b1;
         end
         if (state_q == K_IDLE) begin
            if (kick_req[g]) begin
               state_d = K_WINDUP;
               cnt_d   = WINDUP_LEN;
            end
         end else if (startOfFrame) begin
            if (cnt_q > 8'd1) begin
               cnt_d = cnt_q - 8'd1;
            end else if (state_q == K_WINDUP) begin
               state_d    = K_STRIKE;
               cnt_d      = STRIKE_LEN;
               hit_done_d = 1'b0;
            end else if (state_q == K_STRIKE) begin
               state_d = K_COOLDOWN;
               cnt_d   = COOLDOWN_LEN;
            end else begin
               state_d = K_IDLE;
               cnt_d   = 8'd0;
            end
         end
      end

      // State registers with asynchronous active-low reset.
      always_ff @(posedge clk or negedge resetN) begin
         if (!resetN) begin
            pos_q      <= POS_INIT;
            speed_q    <= '0;
            state_q    <= K_IDLE;
            cnt_q      <= 8'd0;
            hit_done_q <= 1'b0;
            hit_q      <= 1'b0;
            strike_q   <= 1'b0;
         end else begin
            pos_q      <= pos_d;
            speed_q    <= speed_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hit_done_q <= hit_done_d;
            hit_q      <= hit_d;
            strike_q   <= (state_d == K_STRIKE);
         end
      end

      assign topLeftY[11*g +: 11]     = 11'(pos_q >>> FRAC_BITS);
      assign strike_active[g]         = strike_q;
      assign kick_hit[g]              = hit_q;
      assign kick_state_dbg[2*g +: 2] = state_q;
   end

endmodule

// File: tb/tb_rod_motion_ctrl.sv
// Bench for rod_motion_ctrl: directed scenarios plus randomized traffic, all
// compared against a frame-level behavioural model of each rod.
module tb_rod_motion_ctrl;

   localparam int N         = 2;
   localparam int FB        = 6;
   localparam int INIT_Y    = 200;
   localparam int Y_MIN     = 30;
   localparam int Y_MAX     = 450;
   localparam int ROD_H     = 64;
   localparam int MAX_SPD   = 230;
   localparam int ACCEL     = 40;
   localparam int WINDUP    = 2;
   localparam int STRIKE    = 4;
   localparam int COOLDOWN  = 8;
   localparam int LO_FP     = Y_MIN << FB;
   localparam int HI_FP     = (Y_MAX - ROD_H) << FB;

   localparam int PH_IDLE = 0, PH_WINDUP = 1, PH_STRIKE = 2, PH_COOL = 3;
   localparam logic [N-1:0] ROD0 = N'(1);
   localparam logic [N-1:0] ROD1 = N'(2);
   localparam logic [N-1:0] NONE = '0;
   localparam logic [N-1:0] ALL  = '1;

   logic              clk = 1'b0;
   logic              resetN;
   logic              sof;
   logic [N-1:0]      up, down, kick, contact;
   logic [11*N-1:0]   tly;
   logic [N-1:0]      sa, kh;
   logic [2*N-1:0]    dbg;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model, one entry per rod.
   int m_pos[N];
   int m_spd[N];
   int m_phase[N];
   int m_left[N];
   bit m_hit_done[N];
   bit m_hit[N];

   always #5 clk = ~clk;

   rod_motion_ctrl #(
      .NUM_RODS(N), .FRAC_BITS(FB), .INITIAL_Y(INIT_Y), .Y_MIN(Y_MIN),
      .Y_MAX(Y_MAX), .ROD_HEIGHT(ROD_H), .MAX_SPEED(MAX_SPD), .ACCEL(ACCEL),
      .WINDUP_FRAMES(WINDUP), .STRIKE_FRAMES(STRIKE), .COOLDOWN_FRAMES(COOLDOWN)
   ) dut (
      .clk(clk), .resetN(resetN), .startOfFrame(sof),
      .y_up(up), .y_down(down), .kick_req(kick), .ball_contact(contact),
      .topLeftY(tly), .strike_active(sa), .kick_hit(kh), .kick_state_dbg(dbg)
   );

   function automatic int rod_y(int r);
      logic signed [10:0] v;
      v = tly[11*r +: 11];
      return int'(v);
   endfunction

   function automatic void model_reset();
      for (int r = 0; r < N; r++) begin
         m_pos[r] = INIT_Y << FB;
         m_spd[r] = 0;
         m_phase[r] = PH_IDLE;
         m_left[r] = 0;
         m_hit_done[r] = 1'b0;
         m_hit[r] = 1'b0;
      end
   endfunction

   // One clock of rod behaviour as described by the rules of the block.
   function automatic void model_step(int r, bit s, bit u, bit d, bit k, bit c);
      int tgt, spd, np;
      m_hit[r] = 1'b0;
      if (m_phase[r] == PH_STRIKE && c && !m_hit_done[r]) begin
         m_hit[r] = 1'b1;
         m_hit_done[r] = 1'b1;
      end
      if (m_phase[r] == PH_IDLE) begin
         if (k) begin
            m_phase[r] = PH_WINDUP;
            m_left[r] = WINDUP;
         end
      end else if (s) begin
         m_left[r] = m_left[r] - 1;
         if (m_left[r] == 0) begin
            case (m_phase[r])
               PH_WINDUP: begin m_phase[r] = PH_STRIKE; m_left[r] = STRIKE; m_hit_done[r] = 1'b0; end
               PH_STRIKE: begin m_phase[r] = PH_COOL; m_left[r] = COOLDOWN; end
               default:   begin m_phase[r] = PH_IDLE; m_left[r] = 0; end
            endcase
         end
      end
      if (s) begin
         tgt = (u && !d) ? -MAX_SPD : ((d && !u) ? MAX_SPD : 0);
`ifdef ROD_MOTION_INERTIA_EN
         if (m_spd[r] < tgt) spd = (m_spd[r] + ACCEL > tgt) ? tgt : m_spd[r] + ACCEL;
         else                spd = (m_spd[r] - ACCEL < tgt) ? tgt : m_spd[r] - ACCEL;
`else
         spd = tgt;
`endif
         np = m_pos[r] + spd;
         if (np < LO_FP)      begin np = LO_FP; spd = 0; end
         else if (np > HI_FP) begin np = HI_FP; spd = 0; end
         m_pos[r] = np;
         m_spd[r] = spd;
      end
   endfunction

   // Drive one clock of inputs (entered and left at a falling edge).
   task automatic cycle(input logic s, input logic [N-1:0] u, input logic [N-1:0] d,
                        input logic [N-1:0] k, input logic [N-1:0] c);
      sof = s; up = u; down = d; kick = k; contact = c;
      @(posedge clk);
      for (int r = 0; r < N; r++) model_step(r, s, u[r], d[r], k[r], c[r]);
      @(negedge clk);
   endtask

   task automatic do_reset();
      resetN = 1'b0;
      sof = 1'b0; up = '0; down = '0; kick = '0; contact = '0;
      @(negedge clk);
      @(negedge clk);
      resetN = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      resetN = 1'b0;
      sof = 1'b0; up = '0; down = '0; kick = '0; contact = '0;
      model_reset();
      @(negedge clk);
      for (int r = 0; r < N; r++) begin
         n_tests++;
         if (rod_y(r) !== INIT_Y || sa[r] !== 1'b0 || kh[r] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset rod%0d: y=%0d sa=%b kh=%b, want y=%0d sa=0 kh=0", r, rod_y(r), sa[r], kh[r], INIT_Y);
         end
      end
      @(negedge clk);
      resetN = 1'b1;
   endtask

   task automatic test_ramp();
      int want;
      for (int f = 0; f < 7; f++) begin
         cycle(1'b1, NONE, ROD0, NONE, NONE);
         cycle(1'b0, NONE, ROD0, NONE, NONE);
         for (int r = 0; r < N; r++) begin
            n_tests++;
            if (rod_y(r) !== (m_pos[r] >>> FB)) begin
               n_fail++;
               $display("FAIL ramp frame%0d rod%0d: y=%0d want %0d", f, r, rod_y(r), m_pos[r] >>> FB);
            end
         end
      end
`ifdef ROD_MOTION_INERTIA_EN
      want = 216;
`else
      want = 225;
`endif
      n_tests++;
      if (rod_y(0) !== want || rod_y(1) !== INIT_Y) begin
         n_fail++;
         $display("FAIL ramp_final: rod0=%0d rod1=%0d want %0d/%0d", rod_y(0), rod_y(1), want, INIT_Y);
      end
   endtask

   task automatic test_clamp();
      int over;
      over = 0;
      for (int f = 0; f < 200; f++) begin
         cycle(1'b1, NONE, ALL, NONE, NONE);
         cycle(1'b0, NONE, ALL, NONE, NONE);
         if (rod_y(0) > 386) over++;
         n_tests++;
         if (rod_y(0) !== (m_pos[0] >>> FB)) begin
            n_fail++;
            $display("FAIL clamp_down frame%0d: y=%0d want %0d", f, rod_y(0), m_pos[0] >>> FB);
         end
      end
      n_tests++;
      if (over != 0 || rod_y(0) !== 386 || rod_y(1) !== 386) begin
         n_fail++;
         $display("FAIL clamp_bottom: rod0=%0d rod1=%0d overshoots=%0d, want 386 and 0", rod_y(0), rod_y(1), over);
      end
      for (int f = 0; f < 200; f++) begin
         cycle(1'b1, ALL, NONE, NONE, NONE);
         cycle(1'b0, ALL, NONE, NONE, NONE);
         if (rod_y(1) < 30) over++;
         n_tests++;
         if (rod_y(1) !== (m_pos[1] >>> FB)) begin
            n_fail++;
            $display("FAIL clamp_up frame%0d: y=%0d want %0d", f, rod_y(1), m_pos[1] >>> FB);
         end
      end
      n_tests++;
      if (over != 0 || rod_y(0) !== 30 || rod_y(1) !== 30) begin
         n_fail++;
         $display("FAIL clamp_top: rod0=%0d rod1=%0d undershoots=%0d, want 30 and 0", rod_y(0), rod_y(1), over);
      end
   endtask

   task automatic test_single_step();
      int want;
      do_reset();
      cycle(1'b1, ROD0, NONE, NONE, NONE);
      cycle(1'b0, ROD0, NONE, NONE, NONE);
`ifdef ROD_MOTION_INERTIA_EN
      want = 199;
`else
      want = 196;
`endif
      n_tests++;
      if (rod_y(0) !== want) begin
         n_fail++;
         $display("FAIL one_frame_up: y=%0d want %0d", rod_y(0), want);
      end
      for (int f = 0; f < 3; f++) begin
         cycle(1'b1, NONE, NONE, NONE, NONE);
         cycle(1'b0, NONE, NONE, NONE, NONE);
         n_tests++;
         if (rod_y(0) !== (m_pos[0] >>> FB)) begin
            n_fail++;
            $display("FAIL release frame%0d: y=%0d want %0d", f, rod_y(0), m_pos[0] >>> FB);
         end
      end
   endtask

   task automatic test_both_held();
      do_reset();
      for (int f = 0; f < 6; f++) begin
         cycle(1'b1, NONE, ROD0, NONE, NONE);
         cycle(1'b0, NONE, ROD0, NONE, NONE);
      end
      for (int f = 0; f < 8; f++) begin
         cycle(1'b1, ROD0, ROD0, NONE, NONE);
         cycle(1'b0, ROD0, ROD0, NONE, NONE);
         n_tests++;
         if (rod_y(0) !== (m_pos[0] >>> FB)) begin
            n_fail++;
            $display("FAIL both_held frame%0d: y=%0d want %0d", f, rod_y(0), m_pos[0] >>> FB);
         end
      end
   endtask

   task automatic test_kick();
      int sa_cycles, hits;
      logic [N-1:0] kv;
      do_reset();
      sa_cycles = 0;
      hits = 0;
      cycle(1'b0, NONE, NONE, ROD1, ROD1);
      for (int f = 0; f < 14; f++) begin
         for (int h = 0; h < 2; h++) begin
            kv = (m_phase[1] == PH_COOL) ? ROD1 : NONE;
            cycle(h == 0, NONE, NONE, kv, ROD1);
            sa_cycles += int'(sa[1]);
            hits += int'(kh[1]);
            n_tests++;
            if (sa[1] !== (m_phase[1] == PH_STRIKE) || kh[1] !== m_hit[1] || sa[0] !== 1'b0) begin
               n_fail++;
               $display("FAIL kick frame%0d.%0d: sa=%b kh=%b want sa=%b kh=%b", f, h, sa, kh,
                        m_phase[1] == PH_STRIKE, m_hit[1]);
            end
         end
      end
      n_tests++;
      if (sa_cycles != 2 * STRIKE) begin
         n_fail++;
         $display("FAIL strike_length: %0d clks high, want %0d", sa_cycles, 2 * STRIKE);
      end
      n_tests++;
      if (hits != 1) begin
         n_fail++;
         $display("FAIL hit_count: %0d pulses, want 1", hits);
      end
      // Kick request arriving together with a frame strobe in IDLE.
      cycle(1'b1, NONE, NONE, ROD1, NONE);
      cycle(1'b0, NONE, NONE, NONE, NONE);
      cycle(1'b1, NONE, NONE, NONE, NONE);
      cycle(1'b0, NONE, NONE, NONE, NONE);
      n_tests++;
      if (sa[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL rekick_windup: sa=%b want 0", sa[1]);
      end
      cycle(1'b1, NONE, NONE, NONE, NONE);
      cycle(1'b0, NONE, NONE, NONE, NONE);
      n_tests++;
      if (sa[1] !== 1'b1 || sa[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL rekick_strike: sa=%b want %b", sa, ROD1);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      cycle(1'b0, NONE, ALL, ROD0, NONE);
      for (int f = 0; f < 3; f++) begin
         cycle(1'b1, NONE, ALL, NONE, NONE);
         cycle(1'b0, NONE, ALL, NONE, NONE);
      end
      n_tests++;
      if (sa[0] !== 1'b1 || rod_y(0) !== (m_pos[0] >>> FB)) begin
         n_fail++;
         $display("FAIL pre_reset: sa0=%b y=%0d want sa0=1 y=%0d", sa[0], rod_y(0), m_pos[0] >>> FB);
      end
      #2 resetN = 1'b0;
      #1;
      for (int r = 0; r < N; r++) begin
         n_tests++;
         if (rod_y(r) !== INIT_Y || sa[r] !== 1'b0 || kh[r] !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset rod%0d: y=%0d sa=%b kh=%b want %0d/0/0", r, rod_y(r), sa[r], kh[r], INIT_Y);
         end
      end
      @(negedge clk);
      resetN = 1'b1;
      model_reset();
      cycle(1'b1, NONE, ALL, NONE, NONE);
      cycle(1'b0, NONE, ALL, NONE, NONE);
      n_tests++;
`ifdef ROD_MOTION_INERTIA_EN
      if (rod_y(0) !== 200 || rod_y(1) !== 200) begin
`else
      if (rod_y(0) !== 203 || rod_y(1) !== 203) begin
`endif
         n_fail++;
         $display("FAIL post_reset_frame: rod0=%0d rod1=%0d model=%0d", rod_y(0), rod_y(1), m_pos[0] >>> FB);
      end
   endtask

   task automatic test_random();
      logic s;
      logic [N-1:0] u, d, k, c;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         s = ($urandom_range(0, 3) == 0);
         u = N'($urandom);
         d = N'($urandom);
         k = ($urandom_range(0, 7) == 0) ? N'($urandom) : NONE;
         c = N'($urandom);
         cycle(s, u, d, k, c);
         for (int r = 0; r < N; r++) begin
            n_tests++;
            if (rod_y(r) !== (m_pos[r] >>> FB)) begin
               n_fail++;
               $display("FAIL rand_y clk%0d rod%0d: y=%0d want %0d", i, r, rod_y(r), m_pos[r] >>> FB);
            end
            n_tests++;
            if (sa[r] !== (m_phase[r] == PH_STRIKE) || kh[r] !== m_hit[r]) begin
               n_fail++;
               $display("FAIL rand_kick clk%0d rod%0d: sa=%b kh=%b want sa=%b kh=%b", i, r, sa[r], kh[r],
                        m_phase[r] == PH_STRIKE, m_hit[r]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_clamp();
      test_single_step();
      test_both_held();
      test_kick();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
